multicycle_ctrl: RTL

//  Main control FSM for the multicycle RV32 core. It sequences one shared ALU, the IR/PC
//  and the unified instruction/data memory port across FETCH..WRITEBACK. It drives aluop

---
 rtl/multicycle_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM of the multicycle RV32 core. It sequences the shared ALU,
//   the IR/PC registers and the unified instruction/data memory port through
//   FETCH..WRITEBACK for LW, SW, R-type and BEQ. Any other opcode traps.
//
//   Memory states (FETCH, MEMRD, MEMWR) wait for mem_ready. A stall longer than
//   WAIT_LIMIT cycles raises the sticky bus_err flag and parks the FSM in TRAP.
//
// Parameters
//   WAIT_LIMIT  max cycles a memory state waits for mem_ready (>= 2)
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   opcode[6:0]          IR[6:0], valid from DECODE onward
//   zero                 ALU zero flag (combinational, current cycle)
//   mem_ready            memory completes the current access this cycle
//   pc_write, ir_write   load PC / IR (and old-PC register)
//   adr_src              memory address: 0=PC, 1=ALUOut
//   mem_req, mem_write   memory access active / access is a write
//   reg_write            write register file rd
//   alu_src_a[1:0]       00=PC, 01=oldPC, 10=rs1
//   alu_src_b[1:0]       00=rs2, 01=imm, 10=const 4
//   result_src[1:0]      00=ALUOut, 01=mem data, 10=ALU result
//   aluop[1:0]           operation class for alu_cont
//   illegal, bus_err     sticky trap causes, cleared only by reset
//   state_o[3:0]         current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state_o
);

  // aluop encodings understood by alu_cont.
  localparam logic [1:0] ALUOP_LWSW   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam int         CNT_W   = $clog2(WAIT_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_LIMIT - 1);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    TRAP   = 4'd9
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             illegal_q;
  logic             bus_err_q;

  // State register, wait counter and sticky trap flags.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      // Outside memory states the counter idles at zero, which also gives a
      // clean count on every entry into FETCH/MEMRD/MEMWR.
      wait_cnt <= '0;
      unique case (state)
        FETCH, MEMRD, MEMWR: begin
          if (mem_ready) begin
            // A completing access wins even in the limit cycle.
            unique case (state)
              FETCH:   state <= DECODE;
              MEMRD:   state <= MEMWB;
              default: state <= FETCH;
            endcase
          end else if (wait_cnt == CNT_MAX) begin
            bus_err_q <= 1'b1;
            state     <= TRAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DECODE: begin
          unique case (opcode)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= EXECR;
            OP_BEQ:       state <= BEQ;
            default: begin
              illegal_q <= 1'b1;
              state     <= TRAP;
            end
          endcase
        end
        // opcode[5] separates SW (0100011) from LW (0000011).
        MEMADR:  state <= opcode[5] ? MEMWR : MEMRD;
        MEMWB:   state <= FETCH;
        EXECR:   state <= ALUWB;
        ALUWB:   state <= FETCH;
        BEQ:     state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= TRAP;
      endcase
    end
  end

  // Output decode. Outputs depend only on the state register, except
  // pc_write/ir_write in FETCH (mem_ready) and pc_write in BEQ (zero).
  // Gating with rst_n forces every control output low for the whole time
  // reset is asserted, including mid-access, without waiting for a clock.
  // NOTE: every output gets a default before the case, so no path through the
  // block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    aluop      = ALUOP_LWSW;
    if (rst_n) begin
      unique case (state)
        FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          pc_write   = mem_ready;
          ir_write   = mem_ready;
        end
        DECODE: begin
          // Branch target oldPC + imm is parked in ALUOut.
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        MEMRD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        MEMWR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        EXECR: begin
          alu_src_a = 2'b10;
          aluop     = ALUOP_RTYPE;
        end
        ALUWB: begin
          reg_write = 1'b1;
        end
        BEQ: begin
          alu_src_a = 2'b10;
          aluop     = ALUOP_BRANCH;
          pc_write  = zero;
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign state_o = state;

endmodule
